// File: rtl/garage_door_plant.sv
// Behavioural garage door plant: turns UP_M/DN_M motor commands into door travel
// and Up_Max/Dn_Max limit switches, with motor spin-up and stall/illegal-command faults.
module garage_door_plant #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int SPINUP_CYCLES = 2,
    parameter int STALL_CYCLES  = 4,
    parameter int POS_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             Up_Max,
    output logic             Dn_Max,
    output logic [POS_W-1:0] position,
    output logic             moving_up,
    output logic             moving_dn,
    output logic             fault
);

    localparam int SPIN_W  = (SPINUP_CYCLES > 1) ? $clog2(SPINUP_CYCLES) : 1;
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    localparam logic [POS_W-1:0]   POS_TOP    = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0]   POS_TOP_M1 = POS_W'(TRAVEL_CYCLES - 1);
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
    localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(SPINUP_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPIN_UP,
        SPIN_DN,
        MOVE_UP,
        MOVE_DN,
        FAULT
    } state_t;

    state_t             state;
    logic [SPIN_W-1:0]  spin_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               up;
    logic               dn;
    logic               both;

    assign up   = UP_M & ~DN_M;
    assign dn   = DN_M & ~UP_M;
    assign both = UP_M & DN_M;

    assign Up_Max    = (position == POS_TOP);
    assign Dn_Max    = (position == '0);
    assign moving_up = (state == MOVE_UP);
    assign moving_dn = (state == MOVE_DN);
    assign fault     = (state == FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            position  <= '0;
            spin_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            // Stall run length only survives consecutive stall edges in IDLE.
            stall_cnt <= '0;
            if (state != FAULT && both) begin
                state <= FAULT;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (up && !Up_Max) begin
                            state    <= SPIN_UP;
                            spin_cnt <= '0;
                        end else if (dn && !Dn_Max) begin
                            state    <= SPIN_DN;
                            spin_cnt <= '0;
                        end else if ((up && Up_Max) || (dn && Dn_Max)) begin
                            if (stall_cnt == STALL_LAST) state <= FAULT;
                            else stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
                    SPIN_UP: begin
                        if (up) begin
                            if (spin_cnt == SPIN_LAST) state <= MOVE_UP;
                            else spin_cnt <= spin_cnt + SPIN_W'(1);
                        end else if (dn) begin
                            state    <= SPIN_DN;
                            spin_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    SPIN_DN: begin
                        if (dn) begin
                            if (spin_cnt == SPIN_LAST) state <= MOVE_DN;
                            else spin_cnt <= spin_cnt + SPIN_W'(1);
                        end else if (up) begin
                            state    <= SPIN_UP;
                            spin_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MOVE_UP: begin
                        // A reversal can land here already at the limit; stop without moving.
                        if (up) begin
                            if (Up_Max) begin
                                state <= IDLE;
                            end else begin
                                position <= position + POS_ONE;
                                if (position == POS_TOP_M1) state <= IDLE;
                            end
                        end else if (dn) begin
                            state    <= SPIN_DN;
                            spin_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MOVE_DN: begin
                        if (dn) begin
                            if (Dn_Max) begin
                                state <= IDLE;
                            end else begin
                                position <= position - POS_ONE;
                                if (position == POS_ONE) state <= IDLE;
                            end
                        end else if (up) begin
                            state    <= SPIN_UP;
                            spin_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_garage_door_plant.sv
// Randomised and directed bench for garage_door_plant against a travel/spin/stall
// reference model expressed as direction, remaining spin time and stall run length.
module tb_garage_door_plant;

    localparam int T     = 8;
    localparam int SPIN  = 2;
    localparam int STALL = 4;
    localparam int POS_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             UP_M = 1'b0;
    logic             DN_M = 1'b0;
    logic             Up_Max;
    logic             Dn_Max;
    logic [POS_W-1:0] position;
    logic             moving_up;
    logic             moving_dn;
    logic             fault;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int m_pos;
    int m_dir;        // -1 down, 0 none, +1 up
    bit m_moving;     // door in motion (spin-up finished)
    int m_spin_left;  // spin edges still needed
    bit m_fault;
    int m_stall;      // consecutive stall edges

    garage_door_plant #(
        .TRAVEL_CYCLES(T),
        .SPINUP_CYCLES(SPIN),
        .STALL_CYCLES(STALL),
        .POS_W(POS_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .UP_M(UP_M),
        .DN_M(DN_M),
        .Up_Max(Up_Max),
        .Dn_Max(Dn_Max),
        .position(position),
        .moving_up(moving_up),
        .moving_dn(moving_dn),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit u, input bit d, input bit r);
        int  want;
        bit  stall_now;
        stall_now = 1'b0;
        want = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        if (r) begin
            m_pos = 0; m_dir = 0; m_moving = 0; m_spin_left = 0; m_fault = 0; m_stall = 0;
        end else if (!m_fault) begin
            if (u && d) begin
                m_fault = 1;
            end else if (want == 0) begin
                m_dir = 0; m_moving = 0;
            end else if (m_dir == 0) begin
                if ((want > 0 && m_pos == T) || (want < 0 && m_pos == 0)) begin
                    stall_now = 1'b1;
                    m_stall++;
                    if (m_stall == STALL) m_fault = 1;
                end else begin
                    m_dir = want; m_moving = 0; m_spin_left = SPIN;
                end
            end else if (want != m_dir) begin
                m_dir = want; m_moving = 0; m_spin_left = SPIN;
            end else if (!m_moving) begin
                m_spin_left--;
                if (m_spin_left == 0) m_moving = 1;
            end else if ((want > 0 && m_pos == T) || (want < 0 && m_pos == 0)) begin
                m_dir = 0; m_moving = 0;
            end else begin
                m_pos += want;
                if (m_pos == T || m_pos == 0) begin
                    m_dir = 0; m_moving = 0;
                end
            end
            if (!stall_now) m_stall = 0;
        end
    endtask

    function automatic logic [POS_W+4:0] exp_vec();
        return {m_pos == T, m_pos == 0, m_moving && m_dir > 0 && !m_fault,
                m_moving && m_dir < 0 && !m_fault, m_fault, POS_W'(m_pos)};
    endfunction

    function automatic logic [POS_W+4:0] obs_vec();
        return {Up_Max, Dn_Max, moving_up, moving_dn, fault, position};
    endfunction

    // Drive one edge's inputs, advance model, sample 1 time unit after the edge.
    task automatic step(input bit u, input bit d, input bit r);
        UP_M = u; DN_M = d; reset = r;
        @(posedge clk);
        model_edge(u, d, r);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, POS_W'(0)}) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(),
                     {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, POS_W'(0)});
        end
    endtask

    task automatic test_full_open();
        step(1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 11; e++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL full_open edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
            end
            if (e == 2 || e == 3) begin
                checks++;
                if (moving_up !== (e == 3)) begin
                    fails++;
                    $display("FAIL full_open_moving edge %0d: got %b expected %b", e, moving_up, e == 3);
                end
            end
            if (e == 4) begin
                checks++;
                if (Dn_Max !== 1'b0 || position !== POS_W'(1)) begin
                    fails++;
                    $display("FAIL full_open_leave_closed: got Dn_Max=%b pos=%0d expected 0/1", Dn_Max, position);
                end
            end
        end
        checks++;
        if (position !== POS_W'(T) || Up_Max !== 1'b1 || moving_up !== 1'b0) begin
            fails++;
            $display("FAIL full_open_end: got pos=%0d Up_Max=%b moving_up=%b expected %0d/1/0",
                     position, Up_Max, moving_up, T);
        end
    endtask

    task automatic test_partial_reversal();
        bit hit;
        step(1'b0, 1'b0, 1'b1);
        hit = 1'b0;
        for (int e = 0; e < 20 && !hit; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (position == POS_W'(3)) hit = 1'b1;
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (!hit || position !== POS_W'(3) || Up_Max !== 1'b0 || Dn_Max !== 1'b0) begin
            fails++;
            $display("FAIL partial_hold: got pos=%0d Up=%b Dn=%b expected 3/0/0", position, Up_Max, Dn_Max);
        end
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL partial_close edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (position !== POS_W'(0) || Dn_Max !== 1'b1) begin
            fails++;
            $display("FAIL partial_closed: got pos=%0d Dn_Max=%b expected 0/1", position, Dn_Max);
        end
    endtask

    task automatic test_reversal_mid_move();
        bit hit;
        step(1'b0, 1'b0, 1'b1);
        hit = 1'b0;
        for (int e = 0; e < 20 && !hit; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (position == POS_W'(5)) hit = 1'b1;
        end
        checks++;
        if (!hit || moving_up !== 1'b1) begin
            fails++;
            $display("FAIL reversal_setup: got pos=%0d moving_up=%b expected 5/1", position, moving_up);
        end
        for (int e = 1; e <= 4; e++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (position !== POS_W'((e < 4) ? 5 : 4) || obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reversal edge %0d: got %h expected %h", e, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_illegal();
        bit hit;
        step(1'b0, 1'b0, 1'b1);
        hit = 1'b0;
        for (int e = 0; e < 20 && !hit; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (position == POS_W'(2)) hit = 1'b1;
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (!hit || fault !== 1'b1 || position !== POS_W'(2)) begin
            fails++;
            $display("FAIL illegal_cmd: got fault=%b pos=%0d expected 1/2", fault, position);
        end
        for (int e = 0; e < 3; e++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1 || position !== POS_W'(2) || moving_up !== 1'b0) begin
            fails++;
            $display("FAIL fault_sticky: got fault=%b pos=%0d mu=%b expected 1/2/0", fault, position, moving_up);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (fault !== 1'b0 || position !== POS_W'(0) || Dn_Max !== 1'b1) begin
            fails++;
            $display("FAIL fault_clear: got fault=%b pos=%0d Dn=%b expected 0/0/1", fault, position, Dn_Max);
        end
    endtask

    task automatic test_stall();
        bit hit;
        step(1'b0, 1'b0, 1'b1);
        hit = 1'b0;
        for (int e = 0; e < 30 && !hit; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (Up_Max == 1'b1) hit = 1'b1;
        end
        step(1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (!hit || fault !== 1'b0 || Up_Max !== 1'b1) begin
            fails++;
            $display("FAIL stall_short: got fault=%b Up_Max=%b expected 0/1", fault, Up_Max);
        end
        for (int e = 1; e <= 4; e++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (fault !== (e == 4)) begin
                fails++;
                $display("FAIL stall_long edge %0d: got fault=%b expected %b", e, fault, e == 4);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        bit hit;
        step(1'b0, 1'b0, 1'b1);
        hit = 1'b0;
        for (int e = 0; e < 20 && !hit; e++) begin
            step(1'b1, 1'b0, 1'b0);
            if (position == POS_W'(6)) hit = 1'b1;
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (!hit || position !== POS_W'(0) || Dn_Max !== 1'b1 || moving_up !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_move: got pos=%0d Dn=%b mu=%b expected 0/1/0", position, Dn_Max, moving_up);
        end
    endtask

    task automatic test_random();
        bit u, d, r;
        int pick;
        u = 1'b0; d = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 800; e++) begin
            if ($urandom_range(0, 99) < 15) begin
                pick = $urandom_range(0, 99);
                u = (pick >= 25 && pick < 60) || pick >= 95;
                d = (pick >= 60);
            end
            r = m_fault ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 1);
            step(u, d, r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random edge %0d (u=%b d=%b r=%b): got %h expected %h",
                         e, u, d, r, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_edge(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        test_reset();
        test_full_open();
        test_partial_reversal();
        test_reversal_mid_move();
        test_illegal();
        test_stall();
        test_reset_mid_move();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
